// File: rtl/uart_dbg_pkg.sv
// Shared types and default constants for the UART debug bridge.
// Contents:
//   state_t              - bridge FSM states
//   *_DFLT               - default opcode / response bytes and inter-byte timeout
package uart_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      BUS,
      RESP
   } state_t;

   localparam logic [7:0] CMD_RD_DFLT   = 8'h52;  // 'R'
   localparam logic [7:0] CMD_WR_DFLT   = 8'h57;  // 'W'
   localparam logic [7:0] ACK_BYTE_DFLT = 8'h4B;  // 'K'
   localparam logic [7:0] NAK_BYTE_DFLT = 8'h3F;  // '?'

   localparam int TIMEOUT_CYCLES_DFLT = 2_500_000;

endpackage

// File: rtl/uart_dbg_resp_tx.sv
// Response byte sender: holds up to four response bytes (MSB first) and runs
// the tx_data_valid / tx_data_ack handshake, leaving valid low for one cycle
// after every accepted byte before presenting the next one.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                load load_data and start sending
//   load_data [31:0]    response bytes, first byte in [31:24]
//   load_last [1:0]     number of bytes to send minus one
//   tx_data_ack         byte accepted (ignored while valid is low)
//   tx_data [7:0]       byte currently presented
//   tx_data_valid       transmit request
//   done                combinational: last byte is being accepted this cycle
module uart_dbg_resp_tx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [1:0]  load_last,
   input  logic        tx_data_ack,
   output logic [7:0]  tx_data,
   output logic        tx_data_valid,
   output logic        done
);

   logic [31:0] shreg;
   logic [1:0]  left;
   logic        gap;
   logic        accept;

   assign accept  = tx_data_valid && tx_data_ack;
   assign done    = accept && (left == 2'd0);
   assign tx_data = shreg[31:24];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg         <= '0;
         left          <= '0;
         gap           <= 1'b0;
         tx_data_valid <= 1'b0;
      end else if (load) begin
         shreg         <= load_data;
         left          <= load_last;
         gap           <= 1'b0;
         tx_data_valid <= 1'b1;
      end else if (accept) begin
         // shifting zeros in leaves tx_data at 0 once the response is drained
         shreg         <= {shreg[23:0], 8'h00};
         tx_data_valid <= 1'b0;
         gap           <= (left != 2'd0);
         if (left != 2'd0) begin
            left <= left - 2'd1;
         end
      end else if (gap) begin
         gap           <= 1'b0;
         tx_data_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: parses host command frames from the RX byte stream,
// issues one 32-bit read or write on the req/ack bus and returns the
// response bytes through the TX byte handshake.
//   Read : CMD_RD A3 A2 A1 A0          -> D3 D2 D1 D0
//   Write: CMD_WR A3..A0 D3..D0        -> ACK_BYTE
//   Other opcode                       -> NAK_BYTE
// Optional build macro UART_DBG_TIMEOUT_EN: aborts a partial frame after
// TIMEOUT_CYCLES clocks without a received byte in ADDR/DATA.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   rx_data[7:0], rx_data_fresh     received byte + one-cycle strobe
//   tx_data[7:0], tx_data_valid     byte to transmit + request
//   tx_data_ack                     one-cycle strobe: byte accepted
//   bus_req, bus_we                 bus request, 1 = write
//   bus_addr[31:0], bus_wdata[31:0] transaction address / write data
//   bus_rdata[31:0], bus_ack        read data, one-cycle completion strobe
//   busy                            FSM not idle
//   overrun                         sticky: byte dropped in BUS/RESP
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an opcode byte
// ADDR  | shifting in the four address bytes
// DATA  | shifting in the four write-data bytes
// BUS   | bus_req asserted, waiting for bus_ack
// RESP  | sending response bytes; RX bytes here are dropped as overrun
module uart_dbg_bridge
   import uart_dbg_pkg::*;
#(
   parameter logic [7:0] CMD_RD   = CMD_RD_DFLT,
   parameter logic [7:0] CMD_WR   = CMD_WR_DFLT,
   parameter logic [7:0] ACK_BYTE = ACK_BYTE_DFLT,
   parameter logic [7:0] NAK_BYTE = NAK_BYTE_DFLT
`ifdef UART_DBG_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_data_fresh,
   output logic [7:0]  tx_data,
   output logic        tx_data_valid,
   input  logic        tx_data_ack,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        busy,
   output logic        overrun
);

   state_t      state, state_nxt;
   logic [1:0]  cnt;
   logic        is_cmd;
   logic        byte_last;
   logic        timeout_hit;
   logic        resp_load;
   logic [31:0] resp_data;
   logic [1:0]  resp_last;
   logic        resp_done;

   assign is_cmd    = (rx_data == CMD_RD) || (rx_data == CMD_WR);
   assign byte_last = rx_data_fresh && (cnt == 2'd3);
   assign busy      = (state != IDLE);

`ifdef UART_DBG_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] tmr;

   // reloaded by every received byte; only decrements while mid-frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (rx_data_fresh) begin
         tmr <= TMR_INIT;
      end else if (((state == ADDR) || (state == DATA)) && (tmr != '0)) begin
         tmr <= tmr - 1'b1;
      end
   end

   assign timeout_hit = !rx_data_fresh && (tmr == '0);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      resp_load = 1'b0;
      resp_data = '0;
      resp_last = 2'd0;
      case (state)
         IDLE: begin
            if (rx_data_fresh) begin
               if (is_cmd) begin
                  state_nxt = ADDR;
               end else begin
                  state_nxt = RESP;
                  resp_load = 1'b1;
                  resp_data = {NAK_BYTE, 24'h0};
               end
            end
         end
         ADDR: begin
            if (byte_last) begin
               state_nxt = bus_we ? DATA : BUS;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         DATA: begin
            if (byte_last) begin
               state_nxt = BUS;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         BUS: begin
            if (bus_req && bus_ack) begin
               state_nxt = RESP;
               resp_load = 1'b1;
               resp_data = bus_we ? {ACK_BYTE, 24'h0} : bus_rdata;
               resp_last = bus_we ? 2'd0 : 2'd3;
            end
         end
         RESP: begin
            if (resp_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // bus_addr / bus_wdata / bus_we only change in IDLE/ADDR/DATA, so they
   // are inherently stable for the whole time bus_req is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         overrun   <= 1'b0;
      end else begin
         if (rx_data_fresh && ((state == BUS) || (state == RESP))) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (rx_data_fresh && is_cmd) begin
                  bus_we <= (rx_data == CMD_WR);
                  cnt    <= '0;
               end
            end
            ADDR: begin
               if (rx_data_fresh) begin
                  bus_addr <= {bus_addr[23:0], rx_data};
                  cnt      <= cnt + 2'd1;
               end
            end
            DATA: begin
               if (rx_data_fresh) begin
                  bus_wdata <= {bus_wdata[23:0], rx_data};
                  cnt       <= cnt + 2'd1;
               end
            end
            BUS: begin
               bus_req <= !(bus_req && bus_ack);
            end
            default: ;
         endcase
      end
   end

   uart_dbg_resp_tx u_resp_tx (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (resp_load),
      .load_data     (resp_data),
      .load_last     (resp_last),
      .tx_data_ack   (tx_data_ack),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .done          (resp_done)
   );

endmodule

// File: tb/tb_uart_dbg_bridge.sv
module tb_uart_dbg_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_data_fresh;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        tx_data_ack;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        busy;
   logic        overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

`ifdef UART_DBG_TIMEOUT_EN
   uart_dbg_bridge #(.TIMEOUT_CYCLES(100)) dut (
`else
   uart_dbg_bridge dut (
`endif
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_data_fresh (rx_data_fresh),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ack   (tx_data_ack),
      .bus_req       (bus_req),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_ack       (bus_ack),
      .busy          (busy),
      .overrun       (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data       = b;
      rx_data_fresh = 1'b1;
      tick();
      rx_data_fresh = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 20 && bus_req !== 1'b1; i++) tick();
      chk(tag, {31'h0, bus_req}, 32'h1);
   endtask

   // waits (bounded) for a presented byte, checks it, acks it and checks
   // that valid is low in the cycle after the ack
   task automatic tx_byte(input string tag, input logic [7:0] exp);
      for (int i = 0; i < 10 && tx_data_valid !== 1'b1; i++) tick();
      chk({tag, "_valid"}, {31'h0, tx_data_valid}, 32'h1);
      chk({tag, "_data"}, {24'h0, tx_data}, {24'h0, exp});
      tx_data_ack = 1'b1;
      tick();
      tx_data_ack = 1'b0;
      chk({tag, "_gap"}, {31'h0, tx_data_valid}, 32'h0);
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
      send(8'h57);
      for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) send(d[i*8 +: 8]);
      chk({tag, "_req_lat1"}, {31'h0, bus_req}, 32'h0);
      tick();
      chk({tag, "_req_lat2"}, {31'h0, bus_req}, 32'h1);
      chk({tag, "_we"}, {31'h0, bus_we}, 32'h1);
      chk({tag, "_addr"}, bus_addr, a);
      chk({tag, "_wdata"}, bus_wdata, d);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk({tag, "_req_drop"}, {31'h0, bus_req}, 32'h0);
      chk({tag, "_valid_lat"}, {31'h0, tx_data_valid}, 32'h1);
      tx_byte({tag, "_ack"}, 8'h4B);
      chk({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
   endtask

   task automatic send_read(input logic [31:0] a);
      send(8'h52);
      for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
   endtask

   initial begin
      logic [31:0] rd;
      logic        saw_req;

      rst_n         = 1'b0;
      rx_data       = 8'h00;
      rx_data_fresh = 1'b0;
      tx_data_ack   = 1'b0;
      bus_rdata     = 32'h0;
      bus_ack       = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_tx_valid", {31'h0, tx_data_valid}, 32'h0);
      chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
      chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      rst_n = 1'b1;
      tick();

      // write frame
      do_write("wr", 32'h1000_0004, 32'hDEAD_BEEF);

      // read frame with 5 wait cycles on the bus
      send_read(32'h0000_0020);
      wait_req("rd_req");
      chk("rd_we", {31'h0, bus_we}, 32'h0);
      chk("rd_addr", bus_addr, 32'h0000_0020);
      chk("rd_busy", {31'h0, busy}, 32'h1);
      repeat (5) tick();
      chk("rd_req_hold", {31'h0, bus_req}, 32'h1);
      chk("rd_addr_hold", bus_addr, 32'h0000_0020);
      chk("rd_valid_early", {31'h0, tx_data_valid}, 32'h0);
      bus_rdata = 32'h1234_5678;
      bus_ack   = 1'b1;
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      chk("rd_valid_lat", {31'h0, tx_data_valid}, 32'h1);
      tx_byte("rd_b0", 8'h12);
      tx_byte("rd_b1", 8'h34);
      tx_byte("rd_b2", 8'h56);
      tx_byte("rd_b3", 8'h78);
      chk("rd_busy_end", {31'h0, busy}, 32'h0);

      // unknown opcode
      saw_req = 1'b0;
      send(8'hA5);
      saw_req |= bus_req;
      chk("nak_valid", {31'h0, tx_data_valid}, 32'h1);
      chk("nak_busy", {31'h0, busy}, 32'h1);
      tx_byte("nak", 8'h3F);
      saw_req |= bus_req;
      chk("nak_no_req", {31'h0, saw_req}, 32'h0);
      chk("nak_busy_end", {31'h0, busy}, 32'h0);
      chk("nak_overrun", {31'h0, overrun}, 32'h0);

      // overrun: a byte arrives while the read response is being sent
      send_read(32'h0000_0040);
      wait_req("ovr_req");
      bus_rdata = 32'hCAFE_F00D;
      bus_ack   = 1'b1;
      tick();
      bus_ack   = 1'b0;
      rd        = 32'hCAFE_F00D;
      tx_byte("ovr_b0", rd[31:24]);
      tick();
      send(8'h57);
      chk("ovr_set", {31'h0, overrun}, 32'h1);
      chk("ovr_busy", {31'h0, busy}, 32'h1);
      chk("ovr_no_req", {31'h0, bus_req}, 32'h0);
      tx_byte("ovr_b1", rd[23:16]);
      tx_byte("ovr_b2", rd[15:8]);
      tx_byte("ovr_b3", rd[7:0]);
      chk("ovr_busy_end", {31'h0, busy}, 32'h0);
      do_write("ovr_wr", 32'hA5A5_0001, 32'h0102_0304);
      chk("ovr_sticky", {31'h0, overrun}, 32'h1);

      // asynchronous reset while bus_req is high
      send_read(32'h0000_0080);
      wait_req("mid_req");
      #2 rst_n = 1'b0;
      #1;
      chk("mid_bus_req", {31'h0, bus_req}, 32'h0);
      chk("mid_busy", {31'h0, busy}, 32'h0);
      chk("mid_addr", bus_addr, 32'h0);
      chk("mid_overrun", {31'h0, overrun}, 32'h0);
      chk("mid_tx_valid", {31'h0, tx_data_valid}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      do_write("post_rst", 32'h2000_0008, 32'h5555_AAAA);

`ifdef UART_DBG_TIMEOUT_EN
      saw_req = 1'b0;
      send(8'h52);
      send(8'h00);
      for (int i = 0; i < 105; i++) begin
         tick();
         saw_req |= bus_req;
      end
      chk("to_idle", {31'h0, busy}, 32'h0);
      chk("to_no_req", {31'h0, saw_req}, 32'h0);
      send_read(32'h0000_0010);
      wait_req("to_rd_req");
      chk("to_rd_addr", bus_addr, 32'h0000_0010);
      bus_rdata = 32'h89AB_CDEF;
      bus_ack   = 1'b1;
      tick();
      bus_ack   = 1'b0;
      tx_byte("to_b0", 8'h89);
      tx_byte("to_b1", 8'hAB);
      tx_byte("to_b2", 8'hCD);
      tx_byte("to_b3", 8'hEF);
      chk("to_busy_end", {31'h0, busy}, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
